// File: rtl/sigma_stream.sv
// Streaming signed-magnitude accumulator: one sum per in_last-terminated packet, single adder.
// Build option: define SIGMA_SAT_EN to saturate the magnitude on overflow instead of wrapping.
module sigma_stream #(
    parameter int N     = 16,
    parameter int F     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {ACC, DONE} state_t;

    state_t           state;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    // Returns {overflow, sign, magnitude}; -0 operands fold to +0 and a zero result is always +0.
    function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-2:0] ma, mb, mag;
        logic         sa, sb, sign, carry;
        logic [N-1:0] sum;
        ma    = a[N-2:0];
        mb    = b[N-2:0];
        sa    = a[N-1] & (ma != '0);
        sb    = b[N-1] & (mb != '0);
        carry = 1'b0;
        if (sa == sb) begin
            sum   = {1'b0, ma} + {1'b0, mb};
            carry = sum[N-1];
            mag   = sum[N-2:0];
`ifdef SIGMA_SAT_EN
            if (carry) mag = '1;
`endif
            sign  = sa;
        end else if (ma >= mb) begin
            mag  = ma - mb;
            sign = sa;
        end else begin
            mag  = mb - ma;
            sign = sb;
        end
        if (mag == '0) sign = 1'b0;
        return {carry, sign, mag};
    endfunction

    logic [N:0]       add_res;
    logic [N-1:0]     sum_next;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    always_comb begin
        add_res  = sm_add(acc, in_data);
        sum_next = add_res[N-1:0];
        cnt_full = &count;
        cnt_next = cnt_full ? count : count + 1'b1;
        ovf_next = ovf | add_res[N] | cnt_full;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (in_last) begin
                            out_data  <= sum_next;
                            out_count <= cnt_next;
                            out_ovf   <= ovf_next;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            acc       <= '0;
                            count     <= '0;
                            ovf       <= 1'b0;
                            state     <= DONE;
                        end else begin
                            acc   <= sum_next;
                            count <= cnt_next;
                            ovf   <= ovf_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    fraction_fits: assert property (@(posedge clk) F < N);
    no_negative_zero: assert property (@(posedge clk) disable iff (!rst_n)
        out_data != {1'b1, {(N-1){1'b0}}});

endmodule

// File: tb/tb_sigma_stream.sv
// Directed and random checks of sigma_stream (N=16, F=8); honours SIGMA_SAT_EN like the design.
module tb_sigma_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        out_ovf;

    int tests = 0;
    int fails = 0;

    sigma_stream #(.N(16), .F(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference signed-magnitude add done in integer arithmetic.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            output logic o);
        int va, vb, s, m;
        logic neg;
        va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
        vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        s  = va + vb;
        m  = (s < 0) ? -s : s;
        neg = (s < 0);
        o  = (m > 32767);
        if (o) begin
`ifdef SIGMA_SAT_EN
            m = 32767;
`else
            m = m % 32768;
`endif
        end
        if (m == 0) neg = 1'b0;
        return {neg, 15'(m)};
    endfunction

    task automatic push(input logic [15:0] d, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL push_ready: in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic get_result(input string name, input logic [15:0] ed,
                              input logic [7:0] ec, input logic eo);
        int t = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_valid: out_valid=%b required=1", name, out_valid);
        end
        tests++;
        if (out_data !== ed) begin
            fails++;
            $display("FAIL %s_data: out_data=%h required=%h", name, out_data, ed);
        end
        tests++;
        if (out_count !== ec) begin
            fails++;
            $display("FAIL %s_count: out_count=%0d required=%0d", name, out_count, ec);
        end
        tests++;
        if (out_ovf !== eo) begin
            fails++;
            $display("FAIL %s_ovf: out_ovf=%b required=%b", name, out_ovf, eo);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: in_ready=%b required=1", name, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, out_data, out_count, out_ovf} !== 27'd0) begin
            fails++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h count=%0d ovf=%b required all 0",
                     in_ready, out_valid, out_data, out_count, out_ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        wait_ready("reset_ready");
    endtask

    task automatic test_basic();
        push(16'h0100, 1'b0);
        push(16'h0200, 1'b0);
        push(16'h8080, 1'b0);
        push(16'h0040, 1'b0);
        push(16'h8100, 1'b0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_early_valid: out_valid=%b required=0", out_valid);
        end
        push(16'h0010, 1'b1);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL basic_latency: out_valid=%b required=1", out_valid);
        end
        get_result("basic", 16'h01D0, 8'd6, 1'b0);
    endtask

    task automatic test_cancel();
        push(16'h0180, 1'b0);
        push(16'h8180, 1'b1);
        get_result("cancel", 16'h0000, 8'd2, 1'b0);
        push(16'h8000, 1'b1);
        get_result("neg_zero_single", 16'h0000, 8'd1, 1'b0);
    endtask

    task automatic test_backpressure();
        push(16'h0300, 1'b0);
        push(16'h0100, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h0777;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, out_data, out_count, out_ovf} !== {2'b10, 16'h0400, 8'd2, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b data=%h count=%0d ovf=%b required 1 0 0400 2 0",
                         i, out_valid, in_ready, out_data, out_count, out_ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        push(16'h8050, 1'b0);
        push(16'h0020, 1'b1);
        get_result("bp_next", 16'h8030, 8'd2, 1'b0);
    endtask

    task automatic test_overflow();
        push(16'h7F00, 1'b0);
        push(16'h0200, 1'b1);
`ifdef SIGMA_SAT_EN
        get_result("overflow", 16'h7FFF, 8'd2, 1'b1);
`else
        get_result("overflow", 16'h0100, 8'd2, 1'b1);
`endif
    endtask

    task automatic test_reset_mid_packet();
        push(16'h0300, 1'b0);
        push(16'h0300, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: ready=%b valid=%b required 0 0", in_ready, out_valid);
        end
        wait_ready("midreset_ready");
        push(16'h0100, 1'b1);
        get_result("midreset", 16'h0100, 8'd1, 1'b0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 30; p++) begin
            int len;
            logic [15:0] model;
            logic mo, o;
            logic [15:0] term;
            len   = $urandom_range(1, 40);
            model = 16'h0000;
            mo    = 1'b0;
            for (int i = 0; i < len; i++) begin
                term = 16'($urandom);
                if ($urandom_range(0, 3) != 0) term[14:10] = 5'd0;
                model = ref_add(model, term, o);
                mo    = mo | o;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push(term, (i == len - 1));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            get_result($sformatf("rand%0d", p), model, 8'(len), mo);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_cancel();
        test_backpressure();
        test_overflow();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
